// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pool channel scheduler: state encoding and width helper.
package maxpool_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } state_e;

  // ceil(log2(n)) clamped to at least 1 so single-value fields still get a bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w = w + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/maxpool_lat_counter.sv
// Down-counter covering the pooling unit's fixed latency; zero_o marks the final wait cycle.
module maxpool_lat_counter #(
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [LW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/maxpool_channel_scheduler.sv
// Walks one shared 2x2 max-pool unit over D depth channels: issue, wait latency, write slice.
module maxpool_channel_scheduler
  import maxpool_pkg::*;
#(
  parameter int D        = 6,
  parameter int POOL_LAT = 2,
  parameter int CW       = clog2_min1(D),
  parameter int LW       = clog2_min1(POOL_LAT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [CW-1:0] ch_sel,
  output logic          pool_en,
  output logic          wr_en,
  input  logic          wr_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] LAST_CH  = CW'(D - 1);
  localparam logic [LW-1:0] LAT_LOAD = (POOL_LAT > 0) ? LW'(POOL_LAT - 1) : '0;

  state_e        state_q;
  logic [CW-1:0] ch_q;
  logic          pool_en_q;
  logic          wr_en_q;
  logic          busy_q;
  logic          done_q;
  logic          cnt_zero;
  logic          cnt_load;
  logic          cnt_dec;

  assign cnt_load = (state_q == ISSUE);
  assign cnt_dec  = (state_q == WAIT) && !cnt_zero;

  maxpool_lat_counter #(.LW(LW)) u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (LAT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Outputs are registered alongside the state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      pool_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pool_en_q <= 1'b0;
      done_q    <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        ch_q    <= '0;
        wr_en_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_q   <= ISSUE;
              ch_q      <= '0;
              pool_en_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
          ISSUE: begin
            if (POOL_LAT > 0) begin
              state_q <= WAIT;
            end else begin
              state_q <= WRITE;
              wr_en_q <= 1'b1;
            end
          end
          WAIT: begin
            if (cnt_zero) begin
              state_q <= WRITE;
              wr_en_q <= 1'b1;
            end
          end
          WRITE: begin
            if (wr_ready) begin
              wr_en_q <= 1'b0;
              if (ch_q == LAST_CH) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q   <= ISSUE;
                ch_q      <= ch_q + 1'b1;
                pool_en_q <= 1'b1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            ch_q    <= '0;
          end
          default: begin
            state_q <= IDLE;
            ch_q    <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ch_sel  = ch_q;
  assign pool_en = pool_en_q;
  assign wr_en   = wr_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_maxpool_channel_scheduler.sv
// Directed bench for maxpool_channel_scheduler: per-cycle comparison against a timing-formula model.
module tb_maxpool_channel_scheduler;

  logic       clk = 1'b0;
  logic       reset;

  logic       start0, abort0, wr_ready0;
  logic [2:0] ch0;
  logic       pe0, we0, bs0, dn0;

  logic       start_b, abort_b, rdy_b;
  logic [2:0] ch1;
  logic       pe1, we1, bs1, dn1;
  logic [0:0] ch2;
  logic       pe2, we2, bs2, dn2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maxpool_channel_scheduler #(.D(6), .POOL_LAT(2)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
    .ch_sel(ch0), .pool_en(pe0), .wr_en(we0), .wr_ready(wr_ready0),
    .busy(bs0), .done(dn0)
  );

  maxpool_channel_scheduler #(.D(6), .POOL_LAT(0)) dut1 (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .ch_sel(ch1), .pool_en(pe1), .wr_en(we1), .wr_ready(rdy_b),
    .busy(bs1), .done(dn1)
  );

  maxpool_channel_scheduler #(.D(1), .POOL_LAT(1)) dut2 (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .ch_sel(ch2), .pool_en(pe2), .wr_en(we2), .wr_ready(rdy_b),
    .busy(bs2), .done(dn2)
  );

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_chk++;
    if (got !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected outputs in cycle t (start sampled at edge 0) from the documented timing formulas.
  function automatic void exp_at(input int t, input int d, input int l, input int sch,
                                 input int sl, input int ab,
                                 output int pe, output int we, output int bs,
                                 output int dn, output int ch);
    int p, s, wlen, dt;
    pe = 0; we = 0; bs = 0; dn = 0; ch = 0;
    if (ab >= 0 && t > ab) return;
    p = l + 2;
    for (int c = 0; c < d; c++) begin
      s    = 1 + c * p + ((sch >= 0 && c > sch) ? sl : 0);
      wlen = 1 + ((c == sch) ? sl : 0);
      if (t >= s && t <= s + l + wlen) begin
        bs = 1;
        ch = c;
        if (t == s) pe = 1;
        if (t >= s + l + 1) we = 1;
      end
    end
    dt = 1 + d * p + ((sch >= 0) ? sl : 0);
    if (t == dt) begin
      dn = 1;
      ch = d - 1;
    end
  endfunction

  task automatic check_dut(input string nm, input int t, input int d, input int l,
                           input int sch, input int sl, input int ab,
                           input logic pe, input logic we, input logic bs,
                           input logic dn, input logic [31:0] ch);
    int epe, ewe, ebs, edn, ech;
    exp_at(t, d, l, sch, sl, ab, epe, ewe, ebs, edn, ech);
    check($sformatf("%s_pool_en_c%0d", nm, t), {31'd0, pe}, epe);
    check($sformatf("%s_wr_en_c%0d", nm, t), {31'd0, we}, ewe);
    check($sformatf("%s_busy_c%0d", nm, t), {31'd0, bs}, ebs);
    check($sformatf("%s_done_c%0d", nm, t), {31'd0, dn}, edn);
    check($sformatf("%s_ch_sel_c%0d", nm, t), ch, ech);
  endtask

  task automatic check_zero(input string nm, input logic pe, input logic we,
                            input logic bs, input logic dn, input logic [31:0] ch);
    check({nm, "_pool_en"}, {31'd0, pe}, 0);
    check({nm, "_wr_en"}, {31'd0, we}, 0);
    check({nm, "_busy"}, {31'd0, bs}, 0);
    check({nm, "_done"}, {31'd0, dn}, 0);
    check({nm, "_ch_sel"}, ch, 0);
  endtask

  // One run of dut0 (D=6, POOL_LAT=2); optionally also starts dut1/dut2 at cycle 0.
  task automatic run(input int ncyc, input int sch, input int sl, input int ab,
                     input int rep1, input int rep2, input bit with_b);
    int ws;
    ws = 1 + sch * 4 + 3;
    for (int t = 0; t < ncyc; t++) begin
      start0    = (t == 0) || (t == rep1) || (t == rep2);
      start_b   = with_b && (t == 0);
      abort0    = (t == ab);
      wr_ready0 = !(sch >= 0 && t >= ws && t < ws + sl);
      @(posedge clk);
      #1;
      check_dut("d0", t + 1, 6, 2, sch, sl, ab, pe0, we0, bs0, dn0, {29'd0, ch0});
      if (with_b) begin
        check_dut("d1", t + 1, 6, 0, -1, 0, -1, pe1, we1, bs1, dn1, {29'd0, ch1});
        check_dut("d2", t + 1, 1, 1, -1, 0, -1, pe2, we2, bs2, dn2, {31'd0, ch2});
      end
    end
    start0    = 1'b0;
    start_b   = 1'b0;
    abort0    = 1'b0;
    wr_ready0 = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    start0    = 1'b0;
    abort0    = 1'b0;
    wr_ready0 = 1'b1;
    start_b   = 1'b0;
    abort_b   = 1'b0;
    rdy_b     = 1'b1;

    @(posedge clk);
    #1;
    check_zero("rst_d0", pe0, we0, bs0, dn0, {29'd0, ch0});
    check_zero("rst_d1", pe1, we1, bs1, dn1, {29'd0, ch1});
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full runs: D=6/LAT=2, D=6/LAT=0, D=1/LAT=1
    run(30, -1, 0, -1, -1, -1, 1'b1);
    // Three-cycle back-pressure on channel 2's write
    run(32, 2, 3, -1, -1, -1, 1'b0);
    // Start re-pulsed mid-run and during DONE
    run(30, -1, 0, -1, 3, 25, 1'b0);
    // Abort during channel 2 WAIT, then a clean run
    run(16, -1, 0, 10, -1, -1, 1'b0);
    run(30, -1, 0, -1, -1, -1, 1'b0);

    // Asynchronous reset in cycle 7, then a clean run
    run(7, -1, 0, -1, -1, -1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_zero("midrst_d0", pe0, we0, bs0, dn0, {29'd0, ch0});
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run(30, -1, 0, -1, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
